// File: rtl/mem_pkg.sv
// Shared sizing and the write-buffer entry record for the data memory.
package mem_pkg;

    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned WB_DEPTH  = 4;
    localparam int unsigned IDX_W     = 8;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
        logic [31:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-buffer FIFO: entry storage, wrapping pointers, occupancy count and a
// newest-match lookup used to forward buffered stores to loads.
module wb_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_index_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] head_index_o,
    output logic [31:0]      head_data_o,
    output logic [2:0]       count_o,
    output logic             full_o,
    output logic             empty_o,
    input  logic [IDX_W-1:0] lookup_index_i,
    output logic             hit_o,
    output logic [31:0]      hit_data_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t         entries_q [DEPTH];
    logic [PtrW-1:0]   head_q, tail_q;
    logic [2:0]        count_q, count_d;
    logic              pop_eff, push_eff;
    int unsigned       slot;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o      = (count_q == 3'd0);
    assign full_o       = (count_q == 3'(DEPTH));
    assign count_o      = count_q;
    assign head_index_o = entries_q[head_q].index;
    assign head_data_o  = entries_q[head_q].data;

    // When full, a push is only legal alongside a pop (tail then equals head).
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        unique case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Entry storage and pointers; pop clears before push so a full-buffer
    // swap leaves the freshly pushed entry valid in the reused slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_eff) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= ptr_inc(head_q);
            end
            if (push_eff) begin
                entries_q[tail_q].valid <= 1'b1;
                entries_q[tail_q].index <= push_index_i;
                entries_q[tail_q].data  <= push_data_i;
                tail_q                  <= ptr_inc(tail_q);
            end
            count_q <= count_d;
        end
    end

    // Walk oldest to newest so the last match seen is the newest one.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        slot       = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = 32'(head_q) + i;
            if (slot >= DEPTH) begin
                slot = slot - DEPTH;
            end
            if (i < 32'(count_q) && entries_q[slot[PtrW-1:0]].valid &&
                entries_q[slot[PtrW-1:0]].index == lookup_index_i) begin
                hit_o      = 1'b1;
                hit_data_o = entries_q[slot[PtrW-1:0]].data;
            end
        end
    end

endmodule

// File: rtl/data_mem_wb.sv
// Word-addressed data memory fronted by a write buffer. Stores enqueue into
// the buffer and drain into the array whenever the single array port is not
// serving a load; loads forward from the newest matching buffered store.
module data_mem_wb
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = mem_pkg::MEM_WORDS,
    parameter int unsigned WB_DEPTH  = mem_pkg::WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic [2:0]  wb_count,
    output logic        wb_empty,
    output logic        misalign_err
);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             aligned;
    logic             enq;
    logic             drain;
    logic             wb_full;
    logic [IDX_W-1:0] head_index;
    logic [31:0]      head_data;
    logic             hit;
    logic [31:0]      hit_data;
    logic             misalign_d, misalign_q;
    logic             unused_addr;

    // Upper address bits are ignored so addresses wrap around the array.
    assign idx         = data_address[9:2];
    assign aligned     = (data_address[1:0] == 2'b00);
    assign unused_addr = ^data_address[31:10];

    assign enq = mem_write && aligned;
    // A load owns the array port, except when a store hits a full buffer
    // (CPU misuse): then the head is forced out so the store is not lost.
    assign drain = !wb_empty && (!mem_read || (wb_full && enq));

    wb_fifo #(
        .DEPTH(WB_DEPTH)
    ) u_wb_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (enq),
        .push_index_i  (idx),
        .push_data_i   (data_in),
        .pop_i         (drain),
        .head_index_o  (head_index),
        .head_data_o   (head_data),
        .count_o       (wb_count),
        .full_o        (wb_full),
        .empty_o       (wb_empty),
        .lookup_index_i(idx),
        .hit_o         (hit),
        .hit_data_o    (hit_data)
    );

    // Array write port, fed only by buffer drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (drain) begin
            mem_q[head_index] <= head_data;
        end
    end

    // Load data: buffer forwarding takes priority over the array.
    always_comb begin
        data_out = '0;
        if (mem_read && aligned) begin
            data_out = hit ? hit_data : mem_q[idx];
        end
    end

    // Sticky misalignment flag next-state.
    always_comb begin
        misalign_d = misalign_q;
        if ((mem_read || mem_write) && !aligned) begin
            misalign_d = 1'b1;
        end
    end

    // Misalignment flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_data_mem_wb.sv
// Directed bench for data_mem_wb: each task drives one scenario and checks
// its own hand-computed expectations inline.
module tb_data_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_address;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic [2:0]  wb_count;
    logic        wb_empty;
    logic        misalign_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_wb dut (
        .clk         (clk),
        .rst         (rst),
        .data_address(data_address),
        .data_in     (data_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .data_out    (data_out),
        .wb_count    (wb_count),
        .wb_empty    (wb_empty),
        .misalign_err(misalign_err)
    );

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] din);
        mem_read     = rd;
        mem_write    = wr;
        data_address = addr;
        data_in      = din;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        vectors++;
        if (wb_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 0", wb_count);
        end
        vectors++;
        if (wb_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_empty: got %b want 1", wb_empty);
        end
        vectors++;
        if (misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_misalign: got %b want 0", misalign_err);
        end
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_dout_idle: got %h want 0", data_out);
        end
        tick();
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_array_zero: got %h want 0", data_out);
        end
        tick();
        idle();
    endtask

    task automatic test_store_load();
        drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL fwd_load: got %h want deadbeef", data_out);
        end
        vectors++;
        if (wb_count !== 3'd1) begin
            miscompares++;
            $display("FAIL fwd_count: got %0d want 1", wb_count);
        end
        tick();
        idle();
        tick();
        vectors++;
        if (wb_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_empty: got %b want 1", wb_empty);
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL array_load: got %h want deadbeef", data_out);
        end
        tick();
        idle();
    endtask

    task automatic test_full();
        // Stores issued with mem_read held high so nothing drains.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h40 + 32'(4 * k), 32'h11111111 * 32'(k + 1));
            #1;
            vectors++;
            if (data_out !== 32'h0) begin
                miscompares++;
                $display("FAIL full_prewrite%0d: got %h want 0", k, data_out);
            end
            tick();
            vectors++;
            if (wb_count !== 3'(k + 1)) begin
                miscompares++;
                $display("FAIL full_count%0d: got %0d want %0d", k, wb_count, k + 1);
            end
        end
        drive(1'b0, 1'b1, 32'h50, 32'h55555555);
        tick();
        vectors++;
        if (wb_count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_5th_count: got %0d want 4", wb_count);
        end
        drive(1'b1, 1'b0, 32'h50, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h55555555) begin
            miscompares++;
            $display("FAIL full_5th_fwd: got %h want 55555555", data_out);
        end
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h11111111) begin
            miscompares++;
            $display("FAIL full_head_drained: got %h want 11111111", data_out);
        end
        tick();
        idle();
        for (int k = 0; k < 4; k++) tick();
        vectors++;
        if (wb_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drain_empty: got %b want 1", wb_empty);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
            #1;
            vectors++;
            if (data_out !== 32'h11111111 * 32'(k + 1)) begin
                miscompares++;
                $display("FAIL full_readback%0d: got %h want %h", k, data_out,
                         32'h11111111 * 32'(k + 1));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_same_index();
        drive(1'b1, 1'b1, 32'h20, 32'h1);
        tick();
        drive(1'b1, 1'b1, 32'h20, 32'h2);
        #1;
        vectors++;
        if (data_out !== 32'h1) begin
            miscompares++;
            $display("FAIL rw_prewrite: got %h want 1", data_out);
        end
        tick();
        vectors++;
        if (wb_count !== 3'd2) begin
            miscompares++;
            $display("FAIL same_count: got %0d want 2", wb_count);
        end
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h2) begin
            miscompares++;
            $display("FAIL same_newest: got %h want 2", data_out);
        end
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h2) begin
            miscompares++;
            $display("FAIL same_buf_over_array: got %h want 2", data_out);
        end
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h2 || wb_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL same_array_final: got %h empty=%b want 2 empty=1", data_out, wb_empty);
        end
        tick();
        idle();
    endtask

    task automatic test_misalign();
        vectors++;
        if (misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_pre: got %b want 0", misalign_err);
        end
        drive(1'b1, 1'b0, 32'h13, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL misalign_dout: got %h want 0", data_out);
        end
        tick();
        vectors++;
        if (misalign_err !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_set: got %b want 1", misalign_err);
        end
        drive(1'b0, 1'b1, 32'h22, 32'h00000BAD);
        tick();
        vectors++;
        if (wb_count !== 3'd0) begin
            miscompares++;
            $display("FAIL misalign_no_enq: got %0d want 0", wb_count);
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'hDEADBEEF || misalign_err !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_sticky: got %h err=%b want deadbeef err=1",
                     data_out, misalign_err);
        end
        tick();
        idle();
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 32'h404, 32'hCAFEF00D);
        tick();
        drive(1'b1, 1'b0, 32'h004, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wrap_fwd: got %h want cafef00d", data_out);
        end
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 32'h004, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wrap_array: got %h want cafef00d", data_out);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h80 + 32'(4 * k), 32'hA0 + 32'(k));
            tick();
        end
        vectors++;
        if (wb_count !== 3'd3) begin
            miscompares++;
            $display("FAIL rmid_count3: got %0d want 3", wb_count);
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_async: count=%0d empty=%b want 0/1", wb_count, wb_empty);
        end
        vectors++;
        if (misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_misalign_clr: got %b want 0", misalign_err);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL rmid_pending_lost: got %h want 0", data_out);
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL rmid_array_clr: got %h want 0", data_out);
        end
        drive(1'b0, 1'b1, 32'h80, 32'h12345678);
        tick();
        vectors++;
        if (wb_count !== 3'd1) begin
            miscompares++;
            $display("FAIL rmid_first_store: got %0d want 1", wb_count);
        end
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        vectors++;
        if (data_out !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rmid_first_load: got %h want 12345678", data_out);
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_full();
        test_same_index();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_wb.md
DATA_MEM_WB -- requirements
Module: data_mem_wb

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning the number of 32-bit words in the data array.
REQ-002 SHALL have parameter WB_DEPTH, default 4, meaning the number of write-buffer entries.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_address  input  32  byte address from the CPU.
REQ-006 SHALL have port data_in  input  32  store data from the CPU.
REQ-007 SHALL have port mem_read  input  1  load request, this cycle.
REQ-008 SHALL have port mem_write  input  1  store request, this cycle.
REQ-009 SHALL have port data_out  output  32  load data, combinational.
REQ-010 SHALL have port wb_count  output  3  number of valid write-buffer entries.
REQ-011 SHALL have port wb_empty  output  1  high when wb_count is 0.
REQ-012 SHALL have port misalign_err  output  1  sticky flag for a misaligned access.

Function
REQ-013 SHALL use word index data_address[9:2]; address bits 31:10 are ignored, so addresses wrap modulo MEM_WORDS.
REQ-014 SHALL treat any access with data_address[1:0] != 0 as misaligned: no enqueue, data_out = 0, and misalign_err set on the next edge.
REQ-015 SHALL accept an aligned store in the cycle mem_write=1 by enqueuing {index, data_in} at the write-buffer tail on that clock edge.
REQ-016 SHALL drain the oldest entry into the array on any edge where the buffer is non-empty and mem_read=0, at most one entry per cycle.
REQ-017 SHALL defer draining in any cycle with mem_read=1, because the single array port is serving the load.
REQ-018 SHALL drive data_out combinationally when mem_read=1 and the access is aligned.
REQ-019 SHALL take data_out from the newest valid buffer entry whose index matches, or from the array when no entry matches.
REQ-020 SHALL drive data_out = 0 whenever mem_read=0.
REQ-021 SHALL make a store visible to loads from the cycle after it is accepted; store-to-load latency is 1 cycle.
REQ-022 SHALL, when the buffer is full and mem_write=1 (mem_read is then 0), drain the head and enqueue the new entry on the same edge, leaving wb_count at WB_DEPTH with no loss.
REQ-023 SHALL, when the buffer is not full, perform a simultaneous drain and enqueue on one edge, leaving wb_count unchanged.
REQ-024 SHALL, when mem_read=1 and mem_write=1 in the same cycle (CPU misuse), accept the write and return the pre-write value on data_out.
REQ-025 SHALL keep multiple entries to the same index in order; the array ends holding the newest value.
REQ-026 SHALL implement head and tail pointers that wrap modulo WB_DEPTH.
REQ-027 SHALL clear misalign_err only on reset.

Reset
REQ-028 SHALL, on rst=1, immediately and asynchronously empty the buffer: wb_count=0, wb_empty=1, pointers=0.
REQ-029 SHALL, on rst=1, clear misalign_err to 0 and all array words to 0.
REQ-030 SHALL, on reset mid-drain, discard pending stores; no partial array write.
REQ-031 SHALL, after rst deasserts, accept a store at the first rising edge.

Structure
REQ-032 SHALL place MEM_WORDS, WB_DEPTH, index width (8) and the buffer-entry record type (valid, index, data) in shared package mem_pkg.
REQ-033 SHALL contain one sub-module, wb_fifo, providing storage, pointers, count and the newest-match forwarding lookup.
REQ-034 SHALL keep the array and the drain/port arbitration in data_mem_wb.

Verification
REQ-035 SHALL cover: store 0xDEADBEEF to 0x10, load 0x10 next cycle -> data_out=0xDEADBEEF from the buffer; after 1 idle cycle wb_empty=1 and the load still returns 0xDEADBEEF from the array.
REQ-036 SHALL cover: 4 stores with mem_read held 1 between them, then a 5th store -> wb_count stays 4, no value lost; after idle cycles all 5 read back correctly.
REQ-037 SHALL cover: stores 0x1 then 0x2 to 0x20 back-to-back, then a load -> data_out=0x2; after drain the array word 8 = 0x2.
REQ-038 SHALL cover: load from 0x13 -> data_out=0 and misalign_err=1 next cycle, sticky through later aligned accesses.
REQ-039 SHALL cover: store to 0x404 then load 0x004 -> same word (index 1) returned (wrap).
REQ-040 SHALL cover: rst pulsed while wb_count=3 -> wb_count=0 at once; a load of any stored address returns 0.
